sifive_reset_sequencer: RTL and testbench

- Single-clock, parametrised reset sequencer that drives CHANNELS ordered reset outputs.
- Releases resets in ascending order with a programmable inter-stage delay, after a debounced quiet period.
- On a hardware or software reset request, re-asserts the resets in descending order (reverse teardown), then repeats the release sequence.
- Sits after the clock/power-good logic of a chip-level clock domain and feeds per-subsystem reset inputs, for example interconnect, then cores, then debug.

---
 rtl/sifive_reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sifive_reset_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sifive_reset_sequencer.sv
// sifive_reset_sequencer
//   Orders CHANNELS active-high reset outputs. After 2^HOLD_BITS consecutive
//   request-free cycles the channels are released one at a time, lowest index
//   first, STAGE_DELAY cycles apart. A hardware (ext_req) or software (sw_req)
//   request tears the resets down again, highest index first, and the release
//   sequence then restarts from the quiet period.
// Ports:
//   clock    - sole clock
//   reset_n  - synchronous active-low reset
//   ext_req  - asynchronous request, synchronised SYNC flops deep
//   sw_req   - synchronous request, acts on the same edge
//   rst_out  - per-channel resets, thermometer coded (bit 0 releases first)
//   done     - all channels released (RUN)
//   busy     - sequencing in progress (RELEASE or ASSERT)
//   state    - HOLD=0, RELEASE=1, RUN=2, ASSERT=3
module sifive_reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_BITS   = 8,
  parameter int STAGE_DELAY = 16,
  parameter int SYNC        = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ext_req,
  input  logic                sw_req,
  output logic [CHANNELS-1:0] rst_out,
  output logic                done,
  output logic                busy,
  output logic [1:0]          state
);

  localparam int LVL_W  = $clog2(CHANNELS + 1);
  localparam int DCNT_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

  localparam logic [LVL_W-1:0]     LVL_MAX   = LVL_W'(CHANNELS);
  localparam logic [LVL_W-1:0]     LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]     LVL_ZERO  = LVL_W'(0);
  localparam logic [HOLD_BITS-1:0] HCNT_MAX  = {HOLD_BITS{1'b1}};
  localparam logic [HOLD_BITS-1:0] HCNT_ZERO = HOLD_BITS'(0);
  localparam logic [HOLD_BITS-1:0] HCNT_ONE  = HOLD_BITS'(1);
  localparam logic [DCNT_W-1:0]    DCNT_MAX  = DCNT_W'(STAGE_DELAY - 1);
  localparam logic [DCNT_W-1:0]    DCNT_ZERO = DCNT_W'(0);
  localparam logic [DCNT_W-1:0]    DCNT_ONE  = DCNT_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ASSERT  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic [HOLD_BITS-1:0] hcnt_q, hcnt_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic [SYNC-1:0]      sync_q, sync_d;
  logic                 req;
  logic [LVL_W-1:0]     lvl_inc, lvl_dec;

  assign sync_d  = {sync_q[SYNC-2:0], ext_req};
  assign req     = sync_q[SYNC-1] | sw_req;
  assign lvl_inc = lvl_q + LVL_ONE;
  assign lvl_dec = lvl_q - LVL_ONE;

  // State register: all sequencing flops plus the ext_req synchroniser.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      lvl_q   <= LVL_ZERO;
      hcnt_q  <= HCNT_ZERO;
      dcnt_q  <= DCNT_ZERO;
      sync_q  <= {SYNC{1'b0}};
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      sync_q  <= sync_d;
    end
  end

  // Next-state logic: quiet-period debounce, staged release and teardown.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    hcnt_d  = hcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_HOLD: begin
        if (req) begin
          hcnt_d = HCNT_ZERO;
        end else if (hcnt_q == HCNT_MAX) begin
          state_d = ST_RELEASE;
          lvl_d   = LVL_ONE;
          dcnt_d  = DCNT_ZERO;
          hcnt_d  = HCNT_ZERO;
        end else begin
          hcnt_d = hcnt_q + HCNT_ONE;
        end
      end
      ST_RELEASE: begin
        // A request beats a stage increment on the same edge.
        if (req) begin
          lvl_d   = lvl_dec;
          dcnt_d  = DCNT_ZERO;
          hcnt_d  = HCNT_ZERO;
          state_d = (lvl_q == LVL_ONE) ? ST_HOLD : ST_ASSERT;
        end else if (lvl_q == LVL_MAX) begin
          // Only reachable with a single channel: entry already released it.
          state_d = ST_RUN;
          dcnt_d  = DCNT_ZERO;
        end else if (dcnt_q == DCNT_MAX) begin
          lvl_d   = lvl_inc;
          dcnt_d  = DCNT_ZERO;
          state_d = (lvl_inc == LVL_MAX) ? ST_RUN : ST_RELEASE;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      ST_RUN: begin
        if (req) begin
          lvl_d   = lvl_dec;
          dcnt_d  = DCNT_ZERO;
          hcnt_d  = HCNT_ZERO;
          state_d = (lvl_q == LVL_ONE) ? ST_HOLD : ST_ASSERT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ASSERT: begin
        // Requests are ignored until the teardown has finished.
        if (lvl_q == LVL_ZERO) begin
          state_d = ST_HOLD;
          hcnt_d  = HCNT_ZERO;
          dcnt_d  = DCNT_ZERO;
        end else if (dcnt_q == DCNT_MAX) begin
          lvl_d   = lvl_dec;
          dcnt_d  = DCNT_ZERO;
          hcnt_d  = HCNT_ZERO;
          state_d = (lvl_q == LVL_ONE) ? ST_HOLD : ST_ASSERT;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      default: begin
        state_d = ST_HOLD;
        lvl_d   = LVL_ZERO;
        hcnt_d  = HCNT_ZERO;
        dcnt_d  = DCNT_ZERO;
      end
    endcase
  end

  // Output decode from registered state and level only, so outputs are glitch-free.
  always_comb begin
    rst_out = {CHANNELS{1'b1}};
    for (int i = 0; i < CHANNELS; i++) begin
      rst_out[i] = (i >= int'(lvl_q));
    end
    done  = (state_q == ST_RUN);
    busy  = (state_q == ST_RELEASE) || (state_q == ST_ASSERT);
    state = state_q;
  end

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
module tb_sifive_reset_sequencer;

  localparam int HOLD_LEN = 16;
  localparam int CH0 = 4;
  localparam int SD0 = 3;
  localparam int SY0 = 4;
  localparam int P_HOLD = 0;
  localparam int P_REL  = 1;
  localparam int P_RUN  = 2;
  localparam int P_ASRT = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic ext_req = 1'b0;
  logic sw_req  = 1'b0;

  logic [3:0] rst0;
  logic       done0, busy0;
  logic [1:0] st0;
  logic       rst1;
  logic       done1, busy1;
  logic [1:0] st1;
  logic [7:0] act0, act1;

  assign act0 = {rst0, st0, done0, busy0};
  assign act1 = {3'b111, rst1, st1, done1, busy1};

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sifive_reset_sequencer #(.CHANNELS(4), .HOLD_BITS(4), .STAGE_DELAY(3), .SYNC(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .ext_req(ext_req), .sw_req(sw_req),
    .rst_out(rst0), .done(done0), .busy(busy0), .state(st0)
  );

  sifive_reset_sequencer #(.CHANNELS(1), .HOLD_BITS(4), .STAGE_DELAY(1), .SYNC(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .ext_req(ext_req), .sw_req(sw_req),
    .rst_out(rst1), .done(done1), .busy(busy1), .state(st1)
  );

  // Reference model: level derived from elapsed time within each phase.
  int         cfg_ch[2] = '{4, 1};
  int         cfg_sd[2] = '{3, 1};
  int         cfg_sy[2] = '{4, 2};
  int         m_phase[2] = '{0, 0};
  int         m_quiet[2] = '{0, 0};
  int         m_t[2]     = '{0, 0};
  int         m_l0[2]    = '{0, 0};
  int         m_lvl[2]   = '{0, 0};
  logic [7:0] m_hist[2]  = '{8'h00, 8'h00};

  function automatic logic [3:0] therm4(input int l);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (i >= l);
    return v;
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    return {therm4(m_lvl[k]), 2'(m_phase[k]), m_phase[k] == P_RUN,
            (m_phase[k] == P_REL) || (m_phase[k] == P_ASRT)};
  endfunction

  task automatic teardown(input int k);
    m_lvl[k] = m_lvl[k] - 1;
    m_t[k]   = 0;
    if (m_lvl[k] == 0) begin
      m_phase[k] = P_HOLD;
      m_quiet[k] = 0;
    end else begin
      m_phase[k] = P_ASRT;
      m_l0[k]    = m_lvl[k];
    end
  endtask

  task automatic model_step(input int k);
    bit req;
    if (!reset_n) begin
      m_phase[k] = P_HOLD;
      m_quiet[k] = 0;
      m_lvl[k]   = 0;
      m_t[k]     = 0;
      m_hist[k]  = 8'h00;
    end else begin
      req       = m_hist[k][cfg_sy[k]-1] | sw_req;
      m_hist[k] = {m_hist[k][6:0], ext_req};
      if (m_phase[k] == P_HOLD) begin
        if (req) m_quiet[k] = 0;
        else if (m_quiet[k] == HOLD_LEN - 1) begin
          m_phase[k] = P_REL;
          m_lvl[k]   = 1;
          m_t[k]     = 0;
        end else m_quiet[k] = m_quiet[k] + 1;
      end else if (m_phase[k] == P_REL) begin
        if (req) teardown(k);
        else begin
          m_t[k] = m_t[k] + 1;
          if (1 + m_t[k] / cfg_sd[k] >= cfg_ch[k]) begin
            m_lvl[k]   = cfg_ch[k];
            m_phase[k] = P_RUN;
          end else m_lvl[k] = 1 + m_t[k] / cfg_sd[k];
        end
      end else if (m_phase[k] == P_RUN) begin
        if (req) teardown(k);
      end else begin
        m_t[k]   = m_t[k] + 1;
        m_lvl[k] = m_l0[k] - m_t[k] / cfg_sd[k];
        if (m_lvl[k] <= 0) begin
          m_lvl[k]   = 0;
          m_phase[k] = P_HOLD;
          m_quiet[k] = 0;
        end
      end
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  // Thermometer invariant on the 4-channel instance, every cycle.
  always @(negedge clock) begin
    logic [3:0] sh;
    sh = rst0 << 1;
    checks++;
    if ((rst0 | sh) !== rst0) begin
      errors++;
      $display("FAIL thermometer t=%0t: rst_out=%b is not thermometer coded", $time, rst0);
    end
  end

  // One-edge reset, reset-state check, then power-up release timing for n edges.
  task automatic test_power_up(input int n_max);
    int exp_l;
    @(negedge clock);
    reset_n = 1'b0; ext_req = 1'b0; sw_req = 1'b0;
    @(negedge clock);
    checks++;
    if (act0 !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_k0: got %b want %b", act0, {4'b1111, 2'd0, 1'b0, 1'b0});
    end
    checks++;
    if (act1 !== {3'b111, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_k1: got %b want %b", act1, {3'b111, 1'b1, 2'd0, 1'b0, 1'b0});
    end
    reset_n = 1'b1;
    for (int n = 1; n <= n_max; n++) begin
      @(negedge clock);
      exp_l = (n < HOLD_LEN) ? 0 : 1 + (n - HOLD_LEN) / SD0;
      if (exp_l > CH0) exp_l = CH0;
      checks++;
      if (rst0 !== therm4(exp_l) || done0 !== (exp_l == CH0)) begin
        errors++;
        $display("FAIL pwr_timing_k0 edge %0d: rst=%b done=%b want rst=%b done=%b",
                 n, rst0, done0, therm4(exp_l), exp_l == CH0);
      end
      checks++;
      if (rst1 !== (n < HOLD_LEN) || done1 !== (n >= HOLD_LEN + 1)) begin
        errors++;
        $display("FAIL pwr_timing_k1 edge %0d: rst=%b done=%b want rst=%b done=%b",
                 n, rst1, done1, n < HOLD_LEN, n >= HOLD_LEN + 1);
      end
      checks++;
      if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL pwr_model edge %0d: got %b/%b want %b/%b", n, act0, act1, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  // Software request in RUN: reverse teardown then full re-release.
  task automatic test_sw_teardown();
    int exp_l, exp_s;
    sw_req = 1'b1;
    for (int j = 0; j <= 36; j++) begin
      @(negedge clock);
      sw_req = 1'b0;
      if (j < 9)       begin exp_l = 3 - j / SD0; exp_s = P_ASRT; end
      else if (j < 25) begin exp_l = 0; exp_s = P_HOLD; end
      else begin
        exp_l = 1 + (j - 25) / SD0;
        exp_s = P_REL;
        if (exp_l >= CH0) begin exp_l = CH0; exp_s = P_RUN; end
      end
      checks++;
      if (rst0 !== therm4(exp_l) || st0 !== 2'(exp_s)) begin
        errors++;
        $display("FAIL sw_teardown_k0 E+%0d: rst=%b st=%0d want rst=%b st=%0d",
                 j, rst0, st0, therm4(exp_l), exp_s);
      end
      checks++;
      if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL sw_model E+%0d: got %b/%b want %b/%b", j, act0, act1, exp_vec(0), exp_vec(1));
      end
      if (j == 0) begin
        checks++;
        if (st1 !== 2'd0 || rst1 !== 1'b1) begin
          errors++;
          $display("FAIL ch1_run_to_hold: st=%0d rst=%b want st=0 rst=1", st1, rst1);
        end
      end
    end
  endtask

  // ext_req held during HOLD keeps the quiet period from starting.
  task automatic test_ext_hold();
    int exp_l;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1; ext_req = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      checks++;
      if (rst0 !== 4'b1111 || act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL ext_hold_high cyc %0d: got %b/%b want %b/%b", j, act0, act1, exp_vec(0), exp_vec(1));
      end
    end
    ext_req = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clock);
      exp_l = (j < SY0 + HOLD_LEN) ? 0 : 1;
      checks++;
      if (rst0 !== therm4(exp_l) || act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL ext_hold_drop edge %0d: rst=%b want %b (model %b/%b got %b)",
                 j, rst0, therm4(exp_l), exp_vec(0), exp_vec(1), act1);
      end
    end
  endtask

  // Request on the same edge as a RELEASE stage step: the request wins.
  task automatic test_req_wins();
    test_power_up(21);
    checks++;
    if (rst0 !== 4'b1100) begin
      errors++;
      $display("FAIL req_wins_pre: rst=%b want 1100", rst0);
    end
    sw_req = 1'b1;
    @(negedge clock);
    sw_req = 1'b0;
    checks++;
    if (rst0 !== 4'b1110 || st0 !== 2'd3) begin
      errors++;
      $display("FAIL req_wins_edge: rst=%b st=%0d want rst=1110 st=3", rst0, st0);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (rst0 !== 4'b1111 || st0 !== 2'd0 || act1 !== exp_vec(1)) begin
      errors++;
      $display("FAIL req_wins_hold: rst=%b st=%0d k1=%b want rst=1111 st=0 k1=%b", rst0, st0, act1, exp_vec(1));
    end
  endtask

  // Randomised requests and resets against the reference model.
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      checks++;
      if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL random cyc %0d: got %b/%b want %b/%b", c, act0, act1, exp_vec(0), exp_vec(1));
      end
      sw_req  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) ext_req = ~ext_req;
      reset_n = ($urandom_range(0, 999) >= 5);
    end
    sw_req = 1'b0; ext_req = 1'b0; reset_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      checks++;
      if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
        errors++;
        $display("FAIL random_settle cyc %0d: got %b/%b want %b/%b", c, act0, act1, exp_vec(0), exp_vec(1));
      end
    end
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL random_final_done: done0=%b done1=%b want 1 1", done0, done1);
    end
  endtask

  initial begin
    test_power_up(30);
    test_sw_teardown();
    test_ext_hold();
    test_req_wins();
    // Reset mid-ASSERT, then full power-up timing again.
    test_power_up(30);
    sw_req = 1'b1;
    @(negedge clock);
    sw_req = 1'b0;
    repeat (4) @(negedge clock);
    test_power_up(30);
    // Reset mid-RELEASE, then full power-up timing again.
    test_power_up(20);
    test_power_up(30);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
